seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the single-cycle execute-stage ALU. It keeps the existing operand muxing (pc/rs1, rs2/imm) and the 4-bit base-operation encoding. It adds the RV32M multiply/divide set, executed iteratively one bit per cycle. Results are registered and delivered behind a valid/ready handshake so the pipeline can stall on long operations. It sits in the execute stage between the register-file/immediate read and the memory stage.

## Interface
- XLEN, 32, datapath width; power of two, ≥8
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- kill  in  1  synchronous abort of the operation in flight (pipeline flush)
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; high only in IDLE
- a_sel  in  1  1: operand A = pc, 0: rs1
- b_sel  in  1  1: operand B = imm, 0: rs2
- alu_sel  in  4  base-op code (used when m_en=0)
- m_en  in  1  1: M-extension op selected by m_op
- m_op  in  3  RISC-V funct3 of the M op
- pc, rs1, rs2, imm  in  XLEN  operand sources
- out_valid  out  1  one-cycle pulse, out_res valid
- out_res  out  XLEN  result, held until the next out_valid
- busy  out  1  iterative op in flight

## Operation
- Base codes (A, B after muxing):
  - 1000 A+B; 0100 A−B
  - 1110 A<<B[SHW-1:0]; 0111 logical >>; 1011 arithmetic (signed) >>
  - 1100 signed A<B; 0110 unsigned A<B (result 1 or 0)
  - 1111 AND; 0000 OR; 1010 XOR
  - 0001 B; 0010 (A+B) with bit0 cleared; 0011 A+B
  - any other code → 0
- M ops (m_op):
  - 000 MUL low half; 001 MULH s×s high; 010 MULHSU s×u high; 011 MULHU u×u high
  - 100 DIV; 101 DIVU; 110 REM; 111 REMU
  - Operands are always rs1/rs2 (a_sel/b_sel ignored).
- Arithmetic wraps modulo 2^XLEN; products are formed on a 2·XLEN accumulator.
- Multiply: operands converted to magnitudes, shift-add over XLEN iterations, product negated when the sign rule requires it.
- Divide: restoring division on magnitudes over XLEN iterations. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
- Special cases resolved on the fast path, no iteration:
  - divide by zero: quotient all-ones, remainder = dividend
  - signed overflow (−2^(XLEN−1) ÷ −1): quotient = dividend, remainder 0
- FSM: IDLE → MUL or DIV (counter XLEN−1 down to 0) → DONE → IDLE.
  - Fast-path ops never leave IDLE.
- Operands are latched at accept; input changes during busy are ignored.

## Timing
- Reset values: state IDLE, out_valid 0, out_res 0, busy 0, in_ready 1, counter 0.
- Accept happens on a rising edge with in_valid && in_ready. in_valid while in_ready=0 is not accepted; upstream must hold it.
- Base op or M special case: out_valid in cycle N+1 (one cycle after accept); in_ready stays 1. Back-to-back accepts give one result per cycle.
- Iterative M op accepted at N:
  - busy=1 and in_ready=0 from N+1 through N+XLEN+1
  - out_valid at N+XLEN+1 (XLEN+1 latency; 33 cycles at XLEN=32)
  - in_ready returns at N+XLEN+2
- No output backpressure: the consumer must take out_res on the out_valid pulse.
- kill:
  - any state → IDLE next edge; out_valid suppressed, out_res unchanged
  - kill together with in_valid in IDLE: the input is discarded
  - kill in the same cycle as DONE: out_valid not asserted
- reset asserted mid-operation: same as the reset values at the next edge; no partial result escapes.
- Accept in the cycle following out_valid is legal (IDLE).

## Test plan
- Reset held 3 cycles, then released → out_valid=0, out_res=0, in_ready=1, busy=0.
- Base op: a_sel=1, b_sel=1, pc=0x1000, imm=0x10, code 0010 → out_res=0x1010 at N+1. Then rs1=0x80000000, rs2=4, code 1011 → 0xF8000000 on the next cycle.
- MULH rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0x00000000. MULHU on the same operands → 0xFFFFFFFE. Each has out_valid exactly 33 cycles after accept, and in_ready is low throughout.
- DIV −7÷2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU x÷0 → 0xFFFFFFFF at N+1. DIV 0x80000000÷0xFFFFFFFF → 0x80000000 at N+1.
- kill asserted at cycle N+10 of a DIVU → no out_valid, in_ready=1 at N+11. A following ADD 3+4 returns 7 one cycle after its accept.
- Randomised ops at XLEN=32 and XLEN=16 against a reference model, with in_valid asserted while busy and reset pulsed mid-divide → every result matches, and no duplicate or lost out_valid.

Source files
------------

// File: rtl/seq_alu.sv
// Execute-stage ALU: base ops and M-extension special cases finish in one cycle,
// while multiply/divide iterate one bit per cycle behind a valid/ready handshake.
module seq_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            a_sel,
  input  logic            b_sel,
  input  logic [3:0]      alu_sel,
  input  logic            m_en,
  input  logic [2:0]      m_op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  output logic [XLEN-1:0] out_res,
  output logic            busy
);
  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, negr_q, negr_d;
  logic [XLEN-1:0]   fin_q, fin_d, res_q, res_d;
  logic              valid_q, valid_d;

  logic [XLEN-1:0]   op_a, op_b, sum_ab, base_res;
  logic [SHW-1:0]    shamt;
  logic              div_zero, div_ovf, sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b, m_fast_res;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quo, rem, iter_res;
  logic              show;

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  // Result is presented from fin_q and committed to res_q only if not killed.
  assign show      = !kill && (valid_q || (state_q == StDone));
  assign out_valid = show;
  assign out_res   = show ? fin_q : res_q;

  always_comb begin
    op_a     = a_sel ? pc : rs1;
    op_b     = b_sel ? imm : rs2;
    sum_ab   = op_a + op_b;
    shamt    = op_b[SHW-1:0];
    base_res = '0;
    case (alu_sel)
      4'b1000: base_res = sum_ab;
      4'b0100: base_res = op_a - op_b;
      4'b1110: base_res = op_a << shamt;
      4'b0111: base_res = op_a >> shamt;
      4'b1011: base_res = $signed(op_a) >>> shamt;
      4'b1100: base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b0110: base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'b1111: base_res = op_a & op_b;
      4'b0000: base_res = op_a | op_b;
      4'b1010: base_res = op_a ^ op_b;
      4'b0001: base_res = op_b;
      4'b0010: base_res = {sum_ab[XLEN-1:1], 1'b0};
      4'b0011: base_res = sum_ab;
      default: base_res = '0;
    endcase
  end

  always_comb begin
    div_zero   = m_op[2] && (rs2 == '0);
    div_ovf    = m_op[2] && !m_op[0] && (rs1 == MinNeg) && (rs2 == '1);
    m_fast_res = div_zero ? (m_op[1] ? rs1 : '1) : (m_op[1] ? '0 : rs1);
    // MULH and MULHSU take rs1 as signed; only MULH takes rs2 as signed.
    sgn_a      = m_op[2] ? !m_op[0] : (m_op[1] ^ m_op[0]);
    sgn_b      = m_op[2] ? !m_op[0] : (m_op[1:0] == 2'b01);
    neg_a      = sgn_a && rs1[XLEN-1];
    neg_b      = sgn_b && rs2[XLEN-1];
    mag_a      = neg_a ? -rs1 : rs1;
    mag_b      = neg_b ? -rs2 : rs2;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    if (state_q == StMul) begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end else if (div_trial[XLEN]) begin
      acc_step = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    prod = neg_q ? -acc_step : acc_step;
    quo  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = negr_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      iter_res = op_q[1] ? rem : quo;
    end else begin
      iter_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    fin_d   = fin_q;
    valid_d = 1'b0;
    res_d   = show ? fin_q : res_q;
    if (kill) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (!m_en) begin
              fin_d   = base_res;
              valid_d = 1'b1;
            end else if (div_zero || div_ovf) begin
              fin_d   = m_fast_res;
              valid_d = 1'b1;
            end else begin
              state_d = m_op[2] ? StDiv : StMul;
              cnt_d   = SHW'(XLEN - 1);
              acc_d   = {{XLEN{1'b0}}, mag_a};
              opnd_d  = mag_b;
              op_d    = m_op;
              neg_d   = neg_a ^ neg_b;
              negr_d  = neg_a;
            end
          end
        end
        StMul, StDiv: begin
          acc_d = acc_step;
          if (cnt_q == '0) begin
            state_d = StDone;
            fin_d   = iter_res;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      fin_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      fin_q   <= fin_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed cases on a 32-bit instance, then random traffic on
// 32- and 16-bit instances checked every cycle against a timeline reference model.
module tb_seq_alu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    [2];
  logic        kill     [2];
  logic        in_valid [2];
  logic        a_sel    [2];
  logic        b_sel    [2];
  logic [3:0]  alu_sel  [2];
  logic        m_en     [2];
  logic [2:0]  m_op     [2];
  logic [31:0] pc       [2];
  logic [31:0] rs1      [2];
  logic [31:0] rs2      [2];
  logic [31:0] imm      [2];
  logic [1:0]  in_ready, out_valid, busy;
  logic [31:0] res32;
  logic [15:0] res16;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.XLEN(32)) u_dut32 (
    .clock(clk), .reset(reset[0]), .kill(kill[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .a_sel(a_sel[0]), .b_sel(b_sel[0]), .alu_sel(alu_sel[0]),
    .m_en(m_en[0]), .m_op(m_op[0]), .pc(pc[0]), .rs1(rs1[0]), .rs2(rs2[0]), .imm(imm[0]),
    .out_valid(out_valid[0]), .out_res(res32), .busy(busy[0])
  );

  seq_alu #(.XLEN(16)) u_dut16 (
    .clock(clk), .reset(reset[1]), .kill(kill[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .a_sel(a_sel[1]), .b_sel(b_sel[1]), .alu_sel(alu_sel[1]),
    .m_en(m_en[1]), .m_op(m_op[1]), .pc(pc[1][15:0]), .rs1(rs1[1][15:0]),
    .rs2(rs2[1][15:0]), .imm(imm[1][15:0]),
    .out_valid(out_valid[1]), .out_res(res16), .busy(busy[1])
  );

  function automatic logic [31:0] res_of(input int k);
    return (k == 0) ? res32 : {16'h0000, res16};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [63:0] msk_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(input logic [63:0] v, input int w);
    return longint'(v << (64 - w)) >>> (64 - w);
  endfunction

  function automatic bit is_iter(input int w, input logic me, input logic [2:0] mop,
                                 input logic [63:0] r1, input logic [63:0] r2);
    logic [63:0] m, a, b, mn;
    m  = msk_of(w);
    a  = r1 & m;
    b  = r2 & m;
    mn = 64'd1 << (w - 1);
    if (!me) return 1'b0;
    if (mop[2] && b == 0) return 1'b0;
    if (mop[2] && !mop[0] && a == mn && b == m) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] ref_res(input int w, input logic as, input logic bs,
      input logic [3:0] sel, input logic me, input logic [2:0] mop, input logic [63:0] pcv,
      input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] imv);
    logic [63:0] m, a, b, r, mn;
    longint      t;
    int          sh;
    m  = msk_of(w);
    mn = 64'd1 << (w - 1);
    r  = 0;
    if (me) begin
      a = r1 & m;
      b = r2 & m;
      case (mop)
        3'd0: r = a * b;
        3'd1: begin t = sx(a, w) * sx(b, w); t = t >>> w; r = t; end
        3'd2: begin t = sx(a, w) * longint'(b); t = t >>> w; r = t; end
        3'd3: r = (a * b) >> w;
        3'd4: begin
          if (b == 0) r = m;
          else if (a == mn && b == m) r = a;
          else begin t = sx(a, w) / sx(b, w); r = t; end
        end
        3'd5: r = (b == 0) ? m : a / b;
        3'd6: begin
          if (b == 0) r = a;
          else if (a == mn && b == m) r = 0;
          else begin t = sx(a, w) % sx(b, w); r = t; end
        end
        default: r = (b == 0) ? a : a % b;
      endcase
    end else begin
      a  = (as ? pcv : r1) & m;
      b  = (bs ? imv : r2) & m;
      sh = int'(b % 64'(w));
      case (sel)
        4'b1000: r = a + b;
        4'b0100: r = a - b;
        4'b1110: r = a << sh;
        4'b0111: r = a >> sh;
        4'b1011: begin t = sx(a, w) >>> sh; r = t; end
        4'b1100: r = (sx(a, w) < sx(b, w)) ? 64'd1 : 64'd0;
        4'b0110: r = (a < b) ? 64'd1 : 64'd0;
        4'b1111: r = a & b;
        4'b0000: r = a | b;
        4'b1010: r = a ^ b;
        4'b0001: r = b;
        4'b0010: r = (a + b) & ~64'd1;
        4'b0011: r = a + b;
        default: r = 0;
      endcase
    end
    return r & m;
  endfunction

  // Timeline model: cycles left in the busy window, pending results, last shown value.
  int          m_wait  [2] = '{0, 0};
  bit          m_fv    [2] = '{0, 0};
  bit          m_isdiv [2] = '{0, 0};
  logic [63:0] m_fres  [2] = '{0, 0};
  logic [63:0] m_ires  [2] = '{0, 0};
  logic [63:0] m_held  [2] = '{0, 0};
  int          n_vdut  [2] = '{0, 0};
  int          n_vexp  [2] = '{0, 0};

  int          cw;
  bit          c_show;
  logic [63:0] c_shown, c_exp, c_got, c_r;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cw      = (k == 0) ? 32 : 16;
      c_show  = !kill[k] && (m_fv[k] || m_wait[k] == 1);
      c_shown = m_fv[k] ? m_fres[k] : m_ires[k];
      c_exp   = {29'd0, c_show, m_wait[k] == 0, m_wait[k] != 0,
                 c_show ? c_shown[31:0] : m_held[k][31:0]};
      c_got   = {29'd0, out_valid[k], in_ready[k], busy[k], res_of(k)};
      check($sformatf("cycle k=%0d t=%0t {valid,ready,busy,res}", k, $time), c_got, c_exp);
      n_vdut[k] += int'(out_valid[k]);
      n_vexp[k] += int'(c_show);
      if (reset[k]) begin
        m_wait[k] = 0;
        m_fv[k]   = 0;
        m_held[k] = 0;
      end else begin
        if (c_show) m_held[k] = c_shown;
        m_fv[k] = 0;
        if (kill[k]) begin
          m_wait[k] = 0;
        end else if (m_wait[k] > 0) begin
          m_wait[k]--;
        end else if (in_valid[k]) begin
          c_r = ref_res(cw, a_sel[k], b_sel[k], alu_sel[k], m_en[k], m_op[k],
                        pc[k], rs1[k], rs2[k], imm[k]);
          if (is_iter(cw, m_en[k], m_op[k], rs1[k], rs2[k])) begin
            m_wait[k]  = cw + 1;
            m_ires[k]  = c_r;
            m_isdiv[k] = m_op[k][2];
          end else begin
            m_fv[k]   = 1;
            m_fres[k] = c_r;
          end
        end
      end
    end
  end

  // ---------------- directed helpers (instance 0) ----------------
  task automatic issue0(input logic as, input logic bs, input logic [3:0] sel,
                        input logic me, input logic [2:0] mop, input logic [31:0] vpc,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] vim);
    int g;
    g = 0;
    while (in_ready[0] !== 1'b1 && g < 80) begin tick(); g++; end
    a_sel[0] = as; b_sel[0] = bs; alu_sel[0] = sel; m_en[0] = me; m_op[0] = mop;
    pc[0] = vpc; rs1[0] = v1; rs2[0] = v2; imm[0] = vim;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
  endtask

  task automatic wait_res0(input string name, input logic [31:0] exp, input int exp_lat);
    int lat, rdy;
    lat = 1;
    rdy = 0;
    while (out_valid[0] !== 1'b1 && lat < 80) begin
      if (in_ready[0]) rdy++;
      tick();
      lat++;
    end
    check({name, " value"}, res32, exp);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    if (exp_lat > 1) check({name, " in_ready low while busy"}, 64'(rdy), 64'd0);
    else check({name, " in_ready stays high"}, in_ready[0], 1'b1);
  endtask

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
      3:       return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_run(input int k, input int n);
    int w;
    w = (k == 0) ? 32 : 16;
    for (int i = 0; i < n; i++) begin
      in_valid[k] = ($urandom_range(0, 9) < 6);
      a_sel[k]    = 1'($urandom);
      b_sel[k]    = 1'($urandom);
      alu_sel[k]  = 4'($urandom);
      m_en[k]     = 1'($urandom);
      m_op[k]     = 3'($urandom);
      pc[k]       = pick(w);
      rs1[k]      = pick(w);
      rs2[k]      = pick(w);
      imm[k]      = pick(w);
      kill[k]     = ($urandom_range(0, 49) == 0);
      reset[k]    = m_isdiv[k] && m_wait[k] > 5 && m_wait[k] < 12 &&
                    ($urandom_range(0, 3) == 0);
      tick();
    end
    in_valid[k] = 1'b0;
    kill[k]     = 1'b0;
    reset[k]    = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; kill[k] = 1'b0; in_valid[k] = 1'b0; a_sel[k] = 1'b0;
      b_sel[k] = 1'b0; alu_sel[k] = 4'h0; m_en[k] = 1'b0; m_op[k] = 3'h0;
      pc[k] = '0; rs1[k] = '0; rs2[k] = '0; imm[k] = '0;
    end
    repeat (3) tick();
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset k=%0d out_valid", k), out_valid[k], 1'b0);
      check($sformatf("reset k=%0d out_res", k), res_of(k), 32'h0);
      check($sformatf("reset k=%0d in_ready", k), in_ready[k], 1'b1);
      check($sformatf("reset k=%0d busy", k), busy[k], 1'b0);
    end

    // Pin the reference model on hand-computed values.
    check("model mulhu", ref_res(32, 0, 0, 0, 1, 3'd3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0),
          64'hFFFF_FFFE);
    check("model mulhsu", ref_res(32, 0, 0, 0, 1, 3'd2, 0, 32'hFFFF_FFFF, 2, 0),
          64'hFFFF_FFFF);
    check("model rem16", ref_res(16, 0, 0, 0, 1, 3'd6, 0, 16'hFFF9, 2, 0), 64'hFFFF);
    check("model sra16", ref_res(16, 0, 0, 4'b1011, 0, 0, 0, 16'h8000, 4, 0), 64'hF800);

    // Base ops back to back.
    issue0(1, 1, 4'b0010, 0, 3'd0, 32'h1000, 0, 0, 32'h10);
    wait_res0("add-clear-bit0", 32'h0000_1010, 1);
    issue0(0, 0, 4'b1011, 0, 3'd0, 0, 32'h8000_0000, 4, 0);
    wait_res0("sra", 32'hF800_0000, 1);

    // Iterative multiply/divide and fast-path specials.
    issue0(1, 1, 4'h0, 1, 3'd1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    wait_res0("mulh", 32'h0000_0000, 33);
    issue0(0, 0, 4'h0, 1, 3'd3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    wait_res0("mulhu", 32'hFFFF_FFFE, 33);
    issue0(0, 0, 4'h0, 1, 3'd4, 0, 32'hFFFF_FFF9, 2, 0);
    wait_res0("div -7/2", 32'hFFFF_FFFD, 33);
    issue0(0, 0, 4'h0, 1, 3'd6, 0, 32'hFFFF_FFF9, 2, 0);
    wait_res0("rem -7%2", 32'hFFFF_FFFF, 33);
    issue0(0, 0, 4'h0, 1, 3'd5, 0, 32'h0000_1234, 0, 0);
    wait_res0("divu by zero", 32'hFFFF_FFFF, 1);
    issue0(0, 0, 4'h0, 1, 3'd4, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    wait_res0("div overflow", 32'h8000_0000, 1);

    // Kill mid-divide: no result, ready again the next cycle.
    issue0(0, 0, 4'h0, 1, 3'd5, 0, 32'd100, 32'd7, 0);
    repeat (9) tick();
    kill[0] = 1'b1;
    tick();
    kill[0] = 1'b0;
    check("kill in_ready next cycle", in_ready[0], 1'b1);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
        if (out_valid[0]) pulses++;
        tick();
      end
      check("kill suppresses out_valid", 64'(pulses), 64'd0);
    end
    issue0(0, 0, 4'b1000, 0, 3'd0, 0, 32'd3, 32'd4, 0);
    wait_res0("add after kill", 32'd7, 1);

    // Kill together with in_valid in idle discards the op.
    tick();
    rs1[0] = 32'd9; rs2[0] = 32'd9; alu_sel[0] = 4'b1000; m_en[0] = 1'b0;
    in_valid[0] = 1'b1;
    kill[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    kill[0] = 1'b0;
    check("kill+in_valid discarded", out_valid[0], 1'b0);

    // Kill in the DONE cycle: no pulse, result register keeps its value.
    issue0(0, 0, 4'h0, 1, 3'd3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (32) tick();
    kill[0] = 1'b1;
    #1;
    check("kill in done out_valid", out_valid[0], 1'b0);
    check("kill in done out_res", res32, 32'd7);
    tick();
    kill[0] = 1'b0;
    check("kill in done in_ready after", in_ready[0], 1'b1);

    fork
      rand_run(0, 1500);
      rand_run(1, 1500);
    join
    repeat (40) tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("out_valid pulse count k=%0d", k), 64'(n_vdut[k]), 64'(n_vexp[k]));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
